// File: rtl/moo_ccm_fmt.sv
// CCM block formatter: emits B0, A0 and A1..An blocks to the feedback-data register over a valid/ready handshake.
// Optional length checking on start is enabled by defining MOO_CCM_LEN_CHK_EN.
module moo_ccm_fmt #(
    parameter int CNT_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_core,
    input  logic         start,
    input  logic [2:0]   ccm_l,
    input  logic [2:0]   ccm_m,
    input  logic         ccm_adata,
    input  logic [119:0] ccm_nonce,
    input  logic [63:0]  msg_len,
    input  logic [31:0]  blk_cnt,
    input  logic         ccm_rdy,
    output logic [127:0] ccm_d,
    output logic         ccm_vld,
    output logic [1:0]   ccm_kind,
    output logic         ccm_busy,
    output logic         ccm_done,
    output logic         ccm_err
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_B0   = 3'd1;
    localparam logic [2:0] ST_A0   = 3'd2;
    localparam logic [2:0] ST_CTR  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Handshake: a block transfers on a rising clk edge where ccm_vld and
    // ccm_rdy are both high; ccm_d/ccm_kind hold while ccm_vld is high and
    // ccm_rdy is low, and ccm_rdy without ccm_vld has no effect.
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       l_q;
    logic [2:0]       m_q;
    logic             adata_q;
    logic [119:0]     nonce_q;
    logic [63:0]      len_q;
    logic [31:0]      n_q;

    logic hs;
    logic start_ok;
    logic bad_start;

    assign hs       = ccm_vld & ccm_rdy;
    assign start_ok = start & (state == ST_IDLE) & ~clr_core;

`ifdef MOO_CCM_LEN_CHK_EN
    logic [3:0] start_l;
    logic [6:0] start_sh;

    assign start_l   = {1'b0, ccm_l} + 4'd1;
    assign start_sh  = {start_l, 3'b000};
    // Shifting out the L-byte field leaves non-zero only when the value does not fit.
    assign bad_start = (ccm_l == 3'd0)
                     | ((blk_cnt >> start_sh) != 32'd0)
                     | ((msg_len >> start_sh) != 64'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccm_err <= 1'b0;
        end else if (clr_core) begin
            ccm_err <= 1'b0;
        end else if (start_ok) begin
            ccm_err <= bad_start;
        end
    end
`else
    assign bad_start = 1'b0;
    assign ccm_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            l_q     <= '0;
            m_q     <= '0;
            adata_q <= 1'b0;
            nonce_q <= '0;
            len_q   <= '0;
            n_q     <= '0;
        end else if (clr_core) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok && !bad_start) begin
                        l_q     <= ccm_l;
                        m_q     <= ccm_m;
                        adata_q <= ccm_adata;
                        nonce_q <= ccm_nonce;
                        len_q   <= msg_len;
                        n_q     <= blk_cnt;
                        cnt     <= '0;
                        state   <= ST_B0;
                    end
                end
                ST_B0: begin
                    if (hs) begin
                        cnt   <= '0;
                        state <= ST_A0;
                    end
                end
                ST_A0: begin
                    if (hs) begin
                        if (n_q == 32'd0) begin
                            state <= ST_DONE;
                        end else begin
                            cnt   <= CNT_W'(1);
                            state <= ST_CTR;
                        end
                    end
                end
                ST_CTR: begin
                    if (hs) begin
                        if (cnt == CNT_W'(n_q)) begin
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic [7:0]   flags;
    logic [6:0]   field_bits;
    logic [127:0] field_mask;
    logic [127:0] field_val;
    logic [127:0] blk;

    assign flags      = (state == ST_B0) ? {1'b0, adata_q, m_q, l_q} : {5'b00000, l_q};
    assign field_bits = ({4'b0000, l_q} + 7'd1) << 3;
    assign field_mask = (128'd1 << field_bits) - 128'd1;
    assign field_val  = (state == ST_B0) ? {64'd0, len_q} : 128'(cnt);
    // The low L bytes carry the length or counter; anything above them in field_val is dropped.
    assign blk        = ({flags, nonce_q} & ~field_mask) | (field_val & field_mask);

    assign ccm_vld  = (state == ST_B0) | (state == ST_A0) | (state == ST_CTR);
    assign ccm_d    = ccm_vld ? blk : 128'd0;
    assign ccm_kind = (state == ST_CTR) ? 2'b10 : ((state == ST_A0) ? 2'b01 : 2'b00);
    assign ccm_busy = (state != ST_IDLE);
    assign ccm_done = (state == ST_DONE);

endmodule

// File: tb/tb_moo_ccm_fmt.sv
// Self-checking bench for moo_ccm_fmt: byte-level reference model, expected-block queue, randomized handshakes.
// Length-check scenarios compile in when MOO_CCM_LEN_CHK_EN is defined.
module tb_moo_ccm_fmt;
    localparam int W = 130;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr_core = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   ccm_l = '0;
    logic [2:0]   ccm_m = '0;
    logic         ccm_adata = 1'b0;
    logic [119:0] ccm_nonce = '0;
    logic [63:0]  msg_len = '0;
    logic [31:0]  blk_cnt = '0;
    logic         ccm_rdy = 1'b0;
    logic [127:0] ccm_d;
    logic         ccm_vld;
    logic [1:0]   ccm_kind;
    logic         ccm_busy;
    logic         ccm_done;
    logic         ccm_err;

    moo_ccm_fmt #(.CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .clr_core(clr_core), .start(start),
        .ccm_l(ccm_l), .ccm_m(ccm_m), .ccm_adata(ccm_adata), .ccm_nonce(ccm_nonce),
        .msg_len(msg_len), .blk_cnt(blk_cnt), .ccm_rdy(ccm_rdy),
        .ccm_d(ccm_d), .ccm_vld(ccm_vld), .ccm_kind(ccm_kind), .ccm_busy(ccm_busy),
        .ccm_done(ccm_done), .ccm_err(ccm_err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [2:0]   c_l, c_m;
    logic         c_ad;
    logic [119:0] c_nonce;
    logic [63:0]  c_len;
    logic [31:0]  c_n;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int timed_out, stab_bad, err_seen, done_gap, after_done, after_busy;

    function automatic logic [127:0] model_block(input logic is_b0, input logic [63:0] val);
        logic [7:0]   b[16];
        logic [127:0] r;
        int L;
        L = int'(c_l) + 1;
        b[0] = is_b0 ? {1'b0, c_ad, c_m, c_l} : {5'b0, c_l};
        for (int k = 1; k < 16; k++) begin
            if (k <= 15 - L) b[k] = c_nonce[119 - 8*(k-1) -: 8];
            else             b[k] = 8'(val >> (8 * (15 - k)));
        end
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = b[k];
        return r;
    endfunction

    task automatic build_expect();
        exp_q.delete();
        exp_q.push_back({2'b00, model_block(1'b1, c_len)});
        exp_q.push_back({2'b01, model_block(1'b0, 64'd0)});
        for (logic [63:0] i = 1; i <= {32'd0, c_n}; i++) exp_q.push_back({2'b10, model_block(1'b0, i)});
    endtask

    task automatic rand_cfg();
        logic [127:0] r128;
        r128    = {$urandom, $urandom, $urandom, $urandom};
        c_l     = 3'($urandom_range(1, 7));
        c_m     = 3'($urandom_range(0, 7));
        c_ad    = 1'($urandom_range(0, 1));
        c_nonce = r128[119:0];
        c_len   = {$urandom, $urandom};
`ifdef MOO_CCM_LEN_CHK_EN
        if (c_l != 3'd7) c_len = c_len & ((64'd1 << (8 * (int'(c_l) + 1))) - 64'd1);
`endif
        c_n     = 32'($urandom_range(0, 6));
    endtask

    task automatic scramble();
        logic [127:0] r128;
        r128      = {$urandom, $urandom, $urandom, $urandom};
        ccm_l     = 3'($urandom);
        ccm_m     = 3'($urandom);
        ccm_adata = 1'($urandom);
        ccm_nonce = r128[119:0];
        msg_len   = {$urandom, $urandom};
        blk_cnt   = $urandom;
    endtask

    task automatic drive_cfg();
        ccm_l = c_l; ccm_m = c_m; ccm_adata = c_ad; ccm_nonce = c_nonce; msg_len = c_len; blk_cnt = c_n;
    endtask

    // mode 0: rdy held high, 1: rdy pattern 1,0,0,1, 2: random rdy plus stray start pulses
    task automatic run_seq(input int mode, input int budget);
        int cyc, last_acc, done_cyc;
        logic prev_hold;
        logic [W-1:0] prev_out;
        got_q.delete();
        timed_out = 0; stab_bad = 0; err_seen = 0; done_cyc = -1; last_acc = -1; prev_hold = 1'b0;
        @(negedge clk);
        drive_cfg(); start = 1'b1; ccm_rdy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < budget && done_cyc < 0) begin
            if (cyc > 0) @(negedge clk);
            if (ccm_err) err_seen = 1;
            if (prev_hold && ({ccm_kind, ccm_d} !== prev_out)) stab_bad++;
            if (ccm_done) begin
                done_cyc = cyc;
            end else begin
                scramble();
                case (mode)
                    0:       ccm_rdy = 1'b1;
                    1:       ccm_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                    default: ccm_rdy = 1'($urandom_range(0, 1));
                endcase
                start = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
                if (ccm_vld && ccm_rdy) begin
                    got_q.push_back({ccm_kind, ccm_d});
                    last_acc = cyc;
                end
                prev_hold = ccm_vld && !ccm_rdy;
                prev_out  = {ccm_kind, ccm_d};
            end
            cyc++;
        end
        start = 1'b0; ccm_rdy = 1'b0;
        if (done_cyc < 0) timed_out = 1;
        done_gap = done_cyc - last_acc;
        @(negedge clk);
        after_done = int'(ccm_done);
        after_busy = int'(ccm_busy);
    endtask

    task automatic test_reset();
        #1;
        check_cnt++;
        if ({ccm_vld, ccm_busy, ccm_done, ccm_err, ccm_kind} !== 6'd0 || ccm_d !== 128'd0)
            $display("FAIL reset_async: vld/busy/done/err/kind=%b d=%h, expected all 0", {ccm_vld, ccm_busy, ccm_done, ccm_err, ccm_kind}, ccm_d);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++;
        if ({ccm_vld, ccm_busy, ccm_done, ccm_err, ccm_kind} !== 6'd0 || ccm_d !== 128'd0)
            $display("FAIL reset_release: vld/busy/done/err/kind=%b d=%h, expected all 0", {ccm_vld, ccm_busy, ccm_done, ccm_err, ccm_kind}, ccm_d);
        else pass_cnt++;
    endtask

    task automatic test_header();
        logic [127:0] b0_k, a0_k;
        c_l = 3'd1; c_m = 3'd3; c_ad = 1'b1; c_len = 64'h20; c_n = 32'd2;
        c_nonce = 120'h0102030405060708090A0B0C0D_0000;
        b0_k = 128'h59_0102030405060708090A0B0C0D_0020;
        a0_k = 128'h01_0102030405060708090A0B0C0D_0000;
        build_expect();
        run_seq(0, 40);
        check_cnt++;
        if (timed_out != 0 || got_q.size() != 4) $display("FAIL header_count: got %0d blocks timeout=%0d, expected 4", got_q.size(), timed_out);
        else pass_cnt++;
        if (got_q.size() == 4) begin
            check_cnt++;
            if (got_q[0] !== {2'b00, b0_k}) $display("FAIL header_b0: got %h expected %h", got_q[0], {2'b00, b0_k});
            else pass_cnt++;
            check_cnt++;
            if (got_q[1] !== {2'b01, a0_k}) $display("FAIL header_a0: got %h expected %h", got_q[1], {2'b01, a0_k});
            else pass_cnt++;
            for (int k = 0; k < 4; k++) begin
                check_cnt++;
                if (got_q[k] !== exp_q[k]) $display("FAIL header_blk%0d: got %h expected %h", k, got_q[k], exp_q[k]);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (done_gap != 1 || after_done != 0 || after_busy != 0)
            $display("FAIL header_done: gap=%0d after_done=%0d after_busy=%0d, expected 1/0/0", done_gap, after_done, after_busy);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        run_seq(1, 60);
        check_cnt++;
        if (timed_out != 0 || got_q.size() != exp_q.size()) $display("FAIL bp_count: got %0d blocks timeout=%0d, expected %0d", got_q.size(), timed_out, exp_q.size());
        else pass_cnt++;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL bp_blk%0d: got %h expected %h", k, got_q[k], exp_q[k]);
            else pass_cnt++;
        end
        check_cnt++;
        if (stab_bad != 0 || done_gap != 1) $display("FAIL bp_stable: unstable=%0d gap=%0d, expected 0/1", stab_bad, done_gap);
        else pass_cnt++;
    endtask

    task automatic test_empty();
        rand_cfg(); c_n = 32'd0;
        build_expect();
        run_seq(0, 20);
        check_cnt++;
        if (timed_out != 0 || got_q.size() != 2) $display("FAIL empty_count: got %0d blocks timeout=%0d, expected 2", got_q.size(), timed_out);
        else pass_cnt++;
        for (int k = 0; k < got_q.size() && k < 2; k++) begin
            check_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL empty_blk%0d: got %h expected %h", k, got_q[k], exp_q[k]);
            else pass_cnt++;
        end
        check_cnt++;
        if (done_gap != 1 || after_busy != 0) $display("FAIL empty_done: gap=%0d busy=%0d, expected 1/0", done_gap, after_busy);
        else pass_cnt++;
    endtask

    task automatic test_l8();
        rand_cfg(); c_l = 3'd7; c_n = 32'd3;
        build_expect();
        run_seq(2, 200);
        check_cnt++;
        if (timed_out != 0 || got_q.size() != 5) $display("FAIL l8_count: got %0d blocks timeout=%0d, expected 5", got_q.size(), timed_out);
        else pass_cnt++;
        for (int k = 0; k < got_q.size() && k < 5; k++) begin
            check_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL l8_blk%0d: got %h expected %h", k, got_q[k], exp_q[k]);
            else pass_cnt++;
        end
        if (got_q.size() == 5) begin
            check_cnt++;
            if (got_q[4][63:0] !== 64'd3 || got_q[4][127:120] !== 8'h07)
                $display("FAIL l8_last_field: got %h expected flags 07 and field 0000000000000003", got_q[4][127:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            rand_cfg();
            build_expect();
            run_seq(2, 10 * (int'(c_n) + 3) + 100);
            check_cnt++;
            if (timed_out != 0 || got_q.size() != exp_q.size() || stab_bad != 0 || err_seen != 0)
                $display("FAIL rand%0d_flow: blocks=%0d expected %0d timeout=%0d unstable=%0d err=%0d", t, got_q.size(), exp_q.size(), timed_out, stab_bad, err_seen);
            else pass_cnt++;
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
                check_cnt++;
                if (got_q[k] !== exp_q[k]) $display("FAIL rand%0d_blk%0d: got %h expected %h", t, k, got_q[k], exp_q[k]);
                else pass_cnt++;
            end
            check_cnt++;
            if (done_gap != 1 || after_done != 0 || after_busy != 0)
                $display("FAIL rand%0d_done: gap=%0d after_done=%0d after_busy=%0d, expected 1/0/0", t, done_gap, after_done, after_busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        int found;
        rand_cfg(); c_l = 3'd1; c_n = 32'd10;
        found = 0;
        @(negedge clk);
        drive_cfg(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (ccm_vld && ccm_kind == 2'b10 && ccm_d[15:0] == 16'd5) begin
                found = 1; ccm_rdy = 1'b0; clr_core = 1'b1; start = 1'b1;
            end else begin
                ccm_rdy = 1'b1;
                @(negedge clk);
            end
        end
        check_cnt++;
        if (found == 0) $display("FAIL abort_reach: block A5 not seen within 40 cycles, expected it");
        else pass_cnt++;
        @(negedge clk);
        clr_core = 1'b0; start = 1'b0;
        check_cnt++;
        if ({ccm_vld, ccm_busy, ccm_done, ccm_err} !== 4'b0000) $display("FAIL abort_clear: vld/busy/done/err=%b expected 0000", {ccm_vld, ccm_busy, ccm_done, ccm_err});
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if ({ccm_vld, ccm_busy, ccm_done} !== 3'b000) $display("FAIL abort_start_dropped: vld/busy/done=%b expected 000", {ccm_vld, ccm_busy, ccm_done});
        else pass_cnt++;
        rand_cfg();
        build_expect();
        run_seq(0, 40);
        check_cnt++;
        if (timed_out != 0 || got_q.size() != exp_q.size()) $display("FAIL abort_restart_count: got %0d blocks expected %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL abort_restart_blk%0d: got %h expected %h", k, got_q[k], exp_q[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        rand_cfg(); c_n = 32'd4;
        @(negedge clk);
        drive_cfg(); start = 1'b1;
        @(negedge clk);
        start = 1'b0; ccm_rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({ccm_vld, ccm_busy, ccm_done} !== 3'b000) $display("FAIL reset_mid: vld/busy/done=%b expected 000", {ccm_vld, ccm_busy, ccm_done});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++;
        if ({ccm_vld, ccm_busy, ccm_done} !== 3'b000) $display("FAIL reset_mid_after: vld/busy/done=%b expected 000", {ccm_vld, ccm_busy, ccm_done});
        else pass_cnt++;
    endtask

`ifdef MOO_CCM_LEN_CHK_EN
    task automatic test_len_chk();
        logic [2:0]  bad_l[3];
        logic [31:0] bad_n[3];
        logic [63:0] bad_len[3];
        bad_l[0] = 3'd1; bad_n[0] = 32'h10000; bad_len[0] = 64'h10;
        bad_l[1] = 3'd0; bad_n[1] = 32'd1;     bad_len[1] = 64'h1;
        bad_l[2] = 3'd1; bad_n[2] = 32'hFFFF;  bad_len[2] = 64'h10000;
        for (int t = 0; t < 3; t++) begin
            rand_cfg(); c_l = bad_l[t]; c_n = bad_n[t]; c_len = bad_len[t];
            @(negedge clk);
            drive_cfg(); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check_cnt++;
            if ({ccm_err, ccm_vld, ccm_busy, ccm_done} !== 4'b1000)
                $display("FAIL lenchk%0d: err/vld/busy/done=%b expected 1000", t, {ccm_err, ccm_vld, ccm_busy, ccm_done});
            else pass_cnt++;
        end
        clr_core = 1'b1;
        @(negedge clk);
        clr_core = 1'b0;
        check_cnt++;
        if (ccm_err !== 1'b0) $display("FAIL lenchk_clr: err=%b expected 0", ccm_err);
        else pass_cnt++;
        c_l = 3'd1; c_n = 32'h10000;
        @(negedge clk);
        drive_cfg(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rand_cfg(); c_l = 3'd2; c_len = 64'hFFFFFF; c_n = 32'd3;
        build_expect();
        run_seq(0, 40);
        check_cnt++;
        if (err_seen != 0 || timed_out != 0 || got_q.size() != exp_q.size())
            $display("FAIL lenchk_recover: err=%0d timeout=%0d blocks=%0d expected 0/0/%0d", err_seen, timed_out, got_q.size(), exp_q.size());
        else pass_cnt++;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL lenchk_blk%0d: got %h expected %h", k, got_q[k], exp_q[k]);
            else pass_cnt++;
        end
    endtask
`else
    task automatic test_wrap();
        int bad;
        rand_cfg(); c_l = 3'd1; c_n = 32'h10001;
        build_expect();
        run_seq(0, 32'h10001 + 50);
        check_cnt++;
        if (timed_out != 0 || got_q.size() != exp_q.size() || err_seen != 0)
            $display("FAIL wrap_count: got %0d blocks timeout=%0d err=%0d, expected %0d/0/0", got_q.size(), timed_out, err_seen, exp_q.size());
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) if (got_q[k] !== exp_q[k]) bad++;
        check_cnt++;
        if (bad != 0) $display("FAIL wrap_blocks: %0d blocks differ from model, expected 0", bad);
        else pass_cnt++;
        if (got_q.size() == 32'h10003) begin
            check_cnt++;
            if (got_q[32'h10001][15:0] !== 16'h0000 || got_q[32'h10002][15:0] !== 16'h0001)
                $display("FAIL wrap_field: fields %h,%h expected 0000,0001", got_q[32'h10001][15:0], got_q[32'h10002][15:0]);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_header();
        test_backpressure();
        test_empty();
        test_l8();
        test_random();
        test_abort();
        test_reset_mid();
`ifdef MOO_CCM_LEN_CHK_EN
        test_len_chk();
`else
        test_wrap();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
